mdu_hilo: RTL and testbench

- Multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS datapath.
- Takes register-file read data as operands and runs mult/multu/div/divu over a fixed number of cycles.
- Holds results in HI/LO; mfhi/mflo read them back so the result can be written to a GPR.
- mthi/mtlo write HI/LO directly.
- busy lets the hazard unit stall mf*/mt*/md instructions.

---
 rtl/mdu_hilo.sv | 175 +++++++++++++++++
 tb/tb_mdu_hilo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// mdu_hilo: multiply/divide unit holding the architectural HI/LO registers.
// A start latches the fully computed result into pending registers. After a
// fixed latency that result commits to HI/LO and done pulses for one cycle.
// mthi/mtlo write HI/LO directly while the unit is idle.
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu
// (op 100-111). Without it those op codes are rejected.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  input  logic        sel_hi,
  output logic [31:0] rd,
  output logic        busy,
  output logic        done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [31:0]   hi, hi_next;
  logic [31:0]   lo, lo_next;
  logic [63:0]   pend, pend_next;
  logic          pend_we, pend_we_next;
  logic          done_next;

  // Datapath signals for the combinational result of the presented op
  logic               op_valid;
  logic               res_we;
  logic [63:0]        res;
  logic [CW-1:0]      res_lat;
  logic               accept;
  logic [63:0]        sprod;
  logic [63:0]        uprod;
  logic               div_ovf;
  logic signed [31:0] sdividend;
  logic signed [31:0] sdivisor;
  logic signed [31:0] squo;
  logic signed [31:0] srem;
  logic [31:0]        udivisor;
  logic [31:0]        uquo;
  logic [31:0]        urem;

  // Behavioural products and quotients; a zero or overflowing divisor is
  // replaced by 1 so the dividers never see an undefined case
  always_comb begin
    sprod     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    uprod     = {32'b0, A} * {32'b0, B};
    div_ovf   = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    sdividend = A;
    sdivisor  = ((B == 32'b0) || div_ovf) ? 32'sd1 : B;
    squo      = sdividend / sdivisor;
    srem      = sdividend % sdivisor;
    udivisor  = (B == 32'b0) ? 32'd1 : B;
    uquo      = A / udivisor;
    urem      = A % udivisor;
  end

  // Select the result, its write-enable and latency for the requested op
  always_comb begin
    op_valid = 1'b1;
    res_we   = 1'b1;
    res      = 64'b0;
    res_lat  = CW'(MULT_CYCLES);
    case (op)
      3'b000: res = sprod;
      3'b001: res = uprod;
      3'b010: begin
        res_lat = CW'(DIV_CYCLES);
        if (B == 32'b0) begin
          res_we = 1'b0;
        end else if (div_ovf) begin
          res = {32'b0, 32'h8000_0000};
        end else begin
          res = {srem, squo};
        end
      end
      3'b011: begin
        res_lat = CW'(DIV_CYCLES);
        if (B == 32'b0) begin
          res_we = 1'b0;
        end else begin
          res = {urem, uquo};
        end
      end
`ifdef MDU_MADD_EN
      3'b100: res = {hi, lo} + sprod;
      3'b101: res = {hi, lo} + uprod;
      3'b110: res = {hi, lo} - sprod;
      3'b111: res = {hi, lo} - uprod;
`else
      default: begin
        op_valid = 1'b0;
        res_we   = 1'b0;
      end
`endif
    endcase
  end

  assign accept = (state == IDLE) && start && op_valid;

  // Next-state logic: accept/launch in IDLE, count down and commit in RUN
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    hi_next      = hi;
    lo_next      = lo;
    pend_next    = pend;
    pend_we_next = pend_we;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          pend_next    = res;
          pend_we_next = res_we;
          cnt_next     = res_lat;
          state_next   = RUN;
        end else if (!start) begin
          if (hi_we) hi_next = wd;
          if (lo_we) lo_next = wd;
        end
      end
      RUN: begin
        cnt_next = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
          cnt_next   = '0;
          if (pend_we) begin
            hi_next = pend[63:32];
            lo_next = pend[31:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and HI/LO registers; reset drops any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= 32'b0;
      lo      <= 32'b0;
      pend    <= 64'b0;
      pend_we <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      hi      <= hi_next;
      lo      <= lo_next;
      pend    <= pend_next;
      pend_we <= pend_we_next;
      done    <= done_next;
    end
  end

  assign busy = (state == RUN);
  assign rd   = sel_hi ? hi : lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed bench for mdu_hilo with a scoreboard.
// Stimulus pushes expected HI/LO values; the monitor pops them on each done
// pulse (or on an explicit probe request) and reads both registers via sel_hi.
module tb_mdu_hilo;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wd;
  logic        sel_hi;
  logic [31:0] rd;
  logic        busy;
  logic        done;

  exp_t exp_q[$];
  exp_t probe_q[$];
  int   tests;
  int   fails;

  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(a_in), .B(b_in),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .sel_hi(sel_hi), .rd(rd),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Read HI then LO through sel_hi and compare with the expected pair
  task automatic read_back(input exp_t e);
    sel_hi = 1'b1;
    #1;
    check({e.name, "_hi"}, 64'(rd), 64'(e.val[63:32]));
    sel_hi = 1'b0;
    #1;
    check({e.name, "_lo"}, 64'(rd), 64'(e.val[31:0]));
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    sel_hi = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          read_back(e);
        end
      end else if (probe_q.size() > 0) begin
        e = probe_q.pop_front();
        read_back(e);
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int n, input logic [63:0] e, input string nm);
    int cyc;
    exp_q.push_back('{nm, e});
    op    = o;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({nm, "_busy_start"}, 64'(busy), 64'd1);
    cyc = 0;
    while (cyc < n + 3) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    check({nm, "_latency"}, 64'(cyc), 64'(n));
    check({nm, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  task automatic move_to(input logic hw, input logic lw, input logic [31:0] data);
    hi_we = hw;
    lo_we = lw;
    wd    = data;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
  endtask

  task automatic checkOutput(input string nm, input logic bsy, input logic dn);
    check({nm, "_busy"}, 64'(busy), 64'(bsy));
    check({nm, "_done"}, 64'(done), 64'(dn));
  endtask

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a_in  = 32'b0;
    b_in  = 32'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wd    = 32'b0;
    probe_q.push_back('{"reset_state", 64'h0});
    #1;
    checkOutput("reset", 1'b0, 1'b0);
    @(negedge clk);
    #4;
    reset = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(3'b000, 32'hFFFF_FFFF, 32'd2, 5, 64'hFFFF_FFFF_FFFF_FFFE, "mult");
    applyStimulus(3'b001, 32'hFFFF_FFFF, 32'd2, 5, 64'h0000_0001_FFFF_FFFE, "multu");
    applyStimulus(3'b010, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
    applyStimulus(3'b011, 32'd7, 32'd2, 10, 64'h0000_0001_0000_0003, "divu");
    applyStimulus(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000, "div_ovf");

    move_to(1'b1, 1'b0, 32'h1234);
    move_to(1'b0, 1'b1, 32'h5678);
    probe_q.push_back('{"mthi_mtlo", 64'h0000_1234_0000_5678});
    @(posedge clk);
    #1;
    applyStimulus(3'b010, 32'd9, 32'd0, 10, 64'h0000_1234_0000_5678, "div_by_zero");

    exp_q.push_back('{"mult_ignored", 64'h0000_0000_0000_000C});
    op    = 3'b000;
    a_in  = 32'd3;
    b_in  = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    op    = 3'b010;
    a_in  = 32'd100;
    b_in  = 32'd5;
    start = 1'b1;
    hi_we = 1'b1;
    wd    = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    checkOutput("ignored_c3", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("ignored_c4", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("ignored_c5", 1'b0, 1'b1);
    applyStimulus(3'b011, 32'd7, 32'd2, 10, 64'h0000_0001_0000_0003, "back_to_back");

`ifdef MDU_MADD_EN
    move_to(1'b1, 1'b0, 32'd1);
    move_to(1'b0, 1'b1, 32'd0);
    applyStimulus(3'b100, 32'd2, 32'd3, 5, 64'h0000_0001_0000_0006, "madd");
    move_to(1'b1, 1'b1, 32'd0);
    applyStimulus(3'b111, 32'd1, 32'd7, 5, 64'hFFFF_FFFF_FFFF_FFF9, "msubu");
`else
    op    = 3'b100;
    a_in  = 32'd2;
    b_in  = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("invalid_op_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
    end
`endif

    op    = 3'b000;
    a_in  = 32'd5;
    b_in  = 32'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0);
    check("async_reset_rd", 64'(rd), 64'd0);
    probe_q.push_back('{"after_reset", 64'h0});
    @(negedge clk);
    #4;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("post_reset", 1'b0, 1'b0);
    end

    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
    check("probe_queue_empty", 64'(probe_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
